gtx_frame_rx: RTL and testbench

Parametrised receive deframer for the GTX 8b10b GPIO link. It sits between the transceiver's 16-bit RX user interface (`rxdata`/`rxcharisk`, `rxusrclk2` domain) and fabric logic. It carries a configurable-width payload instead of a fixed 2-bit one. It checks each frame's sequence and integrity, and runs a lock/unlock state machine. Payload updates reach the fabric only while the link is locked.

---
 rtl/gtx_frame_rx.sv | 218 +++++++++++++++++++++
 tb/tb_gtx_frame_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_frame_rx.sv
// rtl/gtx_frame_rx.sv - GTX 8b10b receive deframer with sequence/XOR check and lock FSM
module gtx_frame_rx #(
    parameter int WIDTH      = 16,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int HOLD       = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       ctrl_i,
    input  logic [15:0]      data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic [15:0]      err_cnt_o
);

    localparam int N_WORDS   = (WIDTH + 15) / 16;
    // Only the meaningful bits of the last payload word are stored; pad bits
    // take part in the XOR check but never reach data_o.
    localparam int LAST_BITS = WIDTH - 16 * (N_WORDS - 1);
    localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);

    typedef enum logic [1:0] {P_IDLE, P_PAY, P_CHK} pstate_t;
    typedef enum logic [1:0] {L_HUNT, L_CONFIRM, L_LOCKED} lstate_t;

    pstate_t          pstate, p_next;
    lstate_t          lstate, l_next;
    logic [4:0]       idx;
    logic [15:0]      acc;
    logic [7:0]       seq_q;
    logic [7:0]       exp_seq;
    logic [WIDTH-1:0] payload;
    logic [3:0]       good_cnt, good_cnt_n;
    logic [3:0]       bad_cnt, bad_cnt_n;

    logic is_idle, is_sof, is_data;
    logic seq_ok;
    logic start, store, frame_good, frame_bad, stray;
    logic upd_data, drop_lock;

    assign is_idle = (ctrl_i == 2'b11) && (data_i == 16'hBCBC);
    assign is_sof  = (ctrl_i == 2'b01) && (data_i[7:0] == 8'hBC);
    assign is_data = (ctrl_i == 2'b00);
    assign seq_ok  = (lstate == L_HUNT) || (seq_q == exp_seq);

    // Parser state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pstate <= P_IDLE;
        end else begin
            pstate <= p_next;
        end
    end

    // Parser next state: an SOF anywhere mid-frame restarts a new frame
    always_comb begin
        p_next = pstate;
        case (pstate)
            P_IDLE: begin
                if (is_sof) p_next = P_PAY;
            end
            P_PAY: begin
                if (is_data)     p_next = (idx == LAST_IDX) ? P_CHK : P_PAY;
                else if (is_sof) p_next = P_PAY;
                else             p_next = P_IDLE;
            end
            P_CHK: begin
                p_next = is_sof ? P_PAY : P_IDLE;
            end
            default: p_next = P_IDLE;
        endcase
    end

    // Parser outputs: frame start/store strobes and the per-word frame verdict
    always_comb begin
        start      = 1'b0;
        store      = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        stray      = 1'b0;
        case (pstate)
            P_IDLE: begin
                if (is_sof)        start = 1'b1;
                else if (!is_idle) stray = 1'b1;
            end
            P_PAY: begin
                if (is_data) begin
                    store = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                    start     = is_sof;
                end
            end
            P_CHK: begin
                if (is_data) begin
                    if ((data_i == acc) && seq_ok) frame_good = 1'b1;
                    else                           frame_bad  = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                    start     = is_sof;
                end
            end
            default: ;
        endcase
    end

    // Frame datapath: sequence latch, word index, XOR accumulator, payload assembly
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idx     <= '0;
            acc     <= '0;
            seq_q   <= '0;
            payload <= '0;
        end else if (start) begin
            idx   <= '0;
            acc   <= '0;
            seq_q <= data_i[15:8];
        end else if (store) begin
            idx <= idx + 5'd1;
            acc <= acc ^ data_i;
            for (int w = 0; w < N_WORDS - 1; w++) begin
                if (idx == 5'(w)) payload[w*16 +: 16] <= data_i;
            end
            if (idx == LAST_IDX) payload[WIDTH-1 -: LAST_BITS] <= data_i[LAST_BITS-1:0];
        end
    end

    // Lock state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lstate <= L_HUNT;
        end else begin
            lstate <= l_next;
        end
    end

    // Lock next state and run counters, driven only by frame verdicts
    always_comb begin
        l_next     = lstate;
        good_cnt_n = good_cnt;
        bad_cnt_n  = bad_cnt;
        case (lstate)
            L_HUNT: begin
                if (frame_good) begin
                    if (LOCK_CNT == 1) begin
                        l_next     = L_LOCKED;
                        good_cnt_n = 4'd0;
                        bad_cnt_n  = 4'd0;
                    end else begin
                        l_next     = L_CONFIRM;
                        good_cnt_n = 4'd1;
                    end
                end
            end
            L_CONFIRM: begin
                if (frame_good) begin
                    good_cnt_n = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                        l_next     = L_LOCKED;
                        good_cnt_n = 4'd0;
                        bad_cnt_n  = 4'd0;
                    end
                end else if (frame_bad) begin
                    l_next     = L_HUNT;
                    good_cnt_n = 4'd0;
                end
            end
            L_LOCKED: begin
                if (frame_good) begin
                    bad_cnt_n = 4'd0;
                end else if (frame_bad) begin
                    bad_cnt_n = bad_cnt + 4'd1;
                    if (bad_cnt + 4'd1 == 4'(UNLOCK_CNT)) begin
                        l_next     = L_HUNT;
                        bad_cnt_n  = 4'd0;
                        good_cnt_n = 4'd0;
                    end
                end
            end
            default: l_next = L_HUNT;
        endcase
    end

    // Lock outputs: publish payload on good frames that end locked, note lock loss
    always_comb begin
        upd_data  = frame_good && (l_next == L_LOCKED);
        drop_lock = (lstate == L_LOCKED) && (l_next != L_LOCKED);
    end

    // Registered outputs, counters and expected sequence number
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            err_cnt_o <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            exp_seq   <= '0;
        end else begin
            good_cnt <= good_cnt_n;
            bad_cnt  <= bad_cnt_n;
            valid_o  <= upd_data;
            locked_o <= (l_next == L_LOCKED);
            if (upd_data) begin
                data_o <= payload;
            end else if (drop_lock && (HOLD == 0)) begin
                data_o <= '0;
            end
            if (frame_good) exp_seq <= seq_q + 8'd1;
            if ((frame_bad || stray) && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gtx_frame_rx.sv
// tb/tb_gtx_frame_rx.sv - self-checking bench for gtx_frame_rx with a frame-level reference model
module tb_gtx_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  ctrl_a, ctrl_b;
    logic [15:0] data_a, data_b;
    logic [19:0] dout_a;
    logic        valid_a, locked_a;
    logic [15:0] err_a;
    logic [0:0]  dout_b;
    logic        valid_b, locked_b;
    logic [15:0] err_b;

    gtx_frame_rx #(.WIDTH(20), .LOCK_CNT(4), .UNLOCK_CNT(2), .HOLD(0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_a), .data_i(data_a),
        .data_o(dout_a), .valid_o(valid_a), .locked_o(locked_a), .err_cnt_o(err_a)
    );

    gtx_frame_rx #(.WIDTH(1), .LOCK_CNT(1), .UNLOCK_CNT(2), .HOLD(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_b), .data_i(data_b),
        .data_o(dout_b), .valid_o(valid_b), .locked_o(locked_b), .err_cnt_o(err_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model for dut_a: a frame is the list of words received since its SOF
    localparam int NW       = 2;
    localparam int M_LOCK   = 4;
    localparam int M_UNLOCK = 2;

    bit          m_in_frame;
    logic [15:0] m_fw[$];
    logic [7:0]  m_seq, m_exp_seq;
    int          m_mode;   // 0 hunt, 1 confirm, 2 locked
    int          m_goods, m_bads;
    logic [19:0] m_data;
    bit          m_valid;
    logic [15:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_fw.delete(); m_seq = 0; m_exp_seq = 0;
        m_mode = 0; m_goods = 0; m_bads = 0;
        m_data = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_err();
        if (m_err != 16'hFFFF) m_err = m_err + 1;
    endtask

    task automatic model_result(input bit good);
        logic [31:0] cat;
        if (good) begin
            m_exp_seq = m_seq + 8'd1;
            if (m_mode == 2) begin
                m_bads = 0;
            end else begin
                m_goods = (m_mode == 0) ? 1 : m_goods + 1;
                m_mode  = (m_goods == M_LOCK) ? 2 : 1;
                if (m_mode == 2) m_bads = 0;
            end
            if (m_mode == 2) begin
                cat     = {m_fw[1], m_fw[0]};
                m_data  = cat[19:0];
                m_valid = 1;
            end
        end else begin
            model_err();
            if (m_mode == 1) begin
                m_mode = 0;
            end else if (m_mode == 2) begin
                m_bads++;
                if (m_bads == M_UNLOCK) begin
                    m_mode = 0;
                    m_data = 0;
                end
            end
        end
    endtask

    task automatic model_word(input logic [1:0] c, input logic [15:0] d);
        bit          sof, idle, dat;
        logic [15:0] x;
        sof  = (c == 2'b01) && (d[7:0] == 8'hBC);
        idle = (c == 2'b11) && (d == 16'hBCBC);
        dat  = (c == 2'b00);
        m_valid = 0;
        if (!m_in_frame) begin
            if (sof) begin
                m_in_frame = 1; m_seq = d[15:8]; m_fw.delete();
            end else if (!idle) begin
                model_err();
            end
        end else if (dat) begin
            m_fw.push_back(d);
            if (m_fw.size() == NW + 1) begin
                x = 16'h0;
                for (int i = 0; i < NW; i++) x = x ^ m_fw[i];
                model_result((m_fw[NW] == x) && ((m_mode == 0) || (m_seq == m_exp_seq)));
                m_in_frame = 0;
            end
        end else begin
            model_result(0);
            if (sof) begin
                m_seq = d[15:8]; m_fw.delete();
            end else begin
                m_in_frame = 0;
            end
        end
    endtask

    task automatic cycle(input logic [1:0] c, input logic [15:0] d);
        ctrl_a = c;
        data_a = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_word(c, d);
        #1;
        check("a_data_o",   32'(dout_a),   32'(m_data));
        check("a_valid_o",  32'(valid_a),  32'(m_valid));
        check("a_locked_o", 32'(locked_a), 32'(m_mode == 2));
        check("a_err_cnt_o", 32'(err_a),   32'(m_err));
    endtask

    task automatic send_frame(input logic [7:0] seq, input logic [15:0] w0,
                              input logic [15:0] w1, input bit corrupt);
        cycle(2'b01, {seq, 8'hBC});
        cycle(2'b00, w0);
        cycle(2'b00, w1);
        cycle(2'b00, w0 ^ w1 ^ (corrupt ? 16'h0100 : 16'h0000));
    endtask

    task automatic frame20(input logic [7:0] seq, input logic [19:0] pay, input bit corrupt);
        send_frame(seq, pay[15:0], {12'h000, pay[19:16]}, corrupt);
    endtask

    initial begin
        int r;
        model_reset();
        rst_n  = 1'b0;
        ctrl_b = 2'b11; data_b = 16'hBCBC;
        cycle(2'b11, 16'hBCBC);
        cycle(2'b11, 16'hBCBC);
        rst_n = 1'b1;
        check("b_reset_data",   32'(dout_b),   32'h0);
        check("b_reset_valid",  32'(valid_b),  32'h0);
        check("b_reset_locked", 32'(locked_b), 32'h0);
        check("b_reset_err",    32'(err_b),    32'h0);

        // WIDTH=1, LOCK_CNT=1: one good frame locks at once
        ctrl_b = 2'b01; data_b = 16'h33BC; cycle(2'b11, 16'hBCBC);
        ctrl_b = 2'b00; data_b = 16'hFFFF; cycle(2'b11, 16'hBCBC);
        ctrl_b = 2'b00; data_b = 16'hFFFF; cycle(2'b11, 16'hBCBC);
        check("b_lock_locked", 32'(locked_b), 32'h1);
        check("b_lock_data",   32'(dout_b),   32'h1);
        check("b_lock_valid",  32'(valid_b),  32'h1);
        check("b_lock_err",    32'(err_b),    32'h0);
        ctrl_b = 2'b00; data_b = 16'h1234; cycle(2'b11, 16'hBCBC);
        check("b_stray_err",    32'(err_b),    32'h1);
        check("b_stray_locked", 32'(locked_b), 32'h1);
        check("b_stray_valid",  32'(valid_b),  32'h0);
        ctrl_b = 2'b11; data_b = 16'hBCBC;

        // Four good frames lock dut_a
        for (int s = 0; s < 4; s++) begin
            frame20(8'(s), 20'hABCDE, 0);
            if (s == 2) check("a_not_yet_locked", 32'(locked_a), 32'h0);
        end
        check("a_lock_locked", 32'(locked_a), 32'h1);
        check("a_lock_data",   32'(dout_a),   32'hABCDE);
        check("a_lock_valid",  32'(valid_a),  32'h1);
        check("a_lock_err",    32'(err_a),    32'h0);
        send_frame(8'd4, 16'hBCDE, 16'h000A, 0);
        // that frame was seq 4: confirm its check word value matched the literal
        check("a_seq4_valid", 32'(valid_a), 32'h1);

        // One bad frame keeps lock, a good one clears the run, two bad ones drop lock
        frame20(8'd5, 20'h12345, 1);
        check("a_bad1_err",    32'(err_a),    32'h1);
        check("a_bad1_locked", 32'(locked_a), 32'h1);
        check("a_bad1_data",   32'(dout_a),   32'hABCDE);
        frame20(8'd5, 20'h12345, 0);
        check("a_good_data", 32'(dout_a), 32'h12345);
        frame20(8'd6, 20'h11111, 1);
        check("a_bad2_locked", 32'(locked_a), 32'h1);
        frame20(8'd6, 20'h22222, 1);
        check("a_unlock_locked", 32'(locked_a), 32'h0);
        check("a_unlock_data",   32'(dout_a),   32'h0);
        check("a_unlock_err",    32'(err_a),    32'h3);

        // CONFIRM broken by a sequence gap, then relock from seq 8
        frame20(8'd5, 20'h00005, 0);
        frame20(8'd6, 20'h00006, 0);
        frame20(8'd8, 20'h00008, 0);
        check("a_gap_err",    32'(err_a),    32'h4);
        check("a_gap_locked", 32'(locked_a), 32'h0);
        for (int s = 8; s < 12; s++) frame20(8'(s), 20'h30000 + 20'(s), 0);
        check("a_relock_locked", 32'(locked_a), 32'h1);
        check("a_relock_data",   32'(dout_a),   32'h3000B);

        // SOF aborting a frame while locked
        cycle(2'b01, 16'h0CBC);
        cycle(2'b00, 16'h1111);
        cycle(2'b01, 16'h0CBC);
        check("a_abort_err",    32'(err_a),    32'h5);
        check("a_abort_locked", 32'(locked_a), 32'h1);
        cycle(2'b00, 16'hA5A5);
        cycle(2'b00, 16'h0005);
        cycle(2'b00, 16'hA5A0);
        check("a_abort_data",  32'(dout_a),  32'h5A5A5);
        check("a_abort_valid", 32'(valid_a), 32'h1);

        // Reset mid-payload while locked, then relock across the seq wrap
        cycle(2'b01, 16'h0DBC);
        cycle(2'b00, 16'h7777);
        rst_n = 1'b0;
        cycle(2'b00, 16'h8888);
        rst_n = 1'b1;
        check("a_rst_data",   32'(dout_a),   32'h0);
        check("a_rst_locked", 32'(locked_a), 32'h0);
        check("a_rst_err",    32'(err_a),    32'h0);
        for (int s = 254; s < 258; s++) frame20(8'(s), 20'h4C000 + 20'(s), 0);
        check("a_wrap_locked", 32'(locked_a), 32'h1);
        check("a_wrap_err",    32'(err_a),    32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 6) begin
                send_frame(($urandom_range(0, 3) == 0) ? 8'($urandom) : m_exp_seq,
                           16'($urandom), 16'($urandom), $urandom_range(0, 5) == 0);
            end else if (r == 7) begin
                cycle(2'b11, 16'hBCBC);
            end else if (r == 8) begin
                case ($urandom_range(0, 3))
                    0: cycle(2'b10, 16'($urandom));
                    1: cycle(2'b11, 16'h1CBC);
                    2: cycle(2'b01, 16'h55AA);
                    default: cycle(2'b00, 16'($urandom));
                endcase
            end else if (r == 9) begin
                cycle(2'b01, {8'($urandom), 8'hBC});
                cycle(2'b00, 16'($urandom));
            end else if (r == 10 && $urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                cycle(2'($urandom), 16'($urandom));
                rst_n = 1'b1;
            end else begin
                cycle(2'b11, 16'hBCBC);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
